// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with branch/return/jump redirects and a valid/ready fetch handshake.
// Define PC_RAS_EN to add a RAS_DEPTH-entry circular return-address stack for call/return prediction.
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter int               SHIFT     = 2,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_base,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             call,
    input  logic             ret,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             misalign
);
    localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1} << SHIFT;
    localparam logic [WIDTH-1:0] LOW  = STEP - 1'b1;
    logic [WIDTH-1:0] pc_q, pc_d, br_tgt, rdr_tgt, ras_top;
    logic             fv_q, fv_d, mis_q, mis_d, fire, redirect, ras_hit;
`ifdef PC_RAS_EN
    localparam int PW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_d, wr_ptr;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(RAS_DEPTH - 1) : p - 1'b1;
    endfunction
    assign pop     = ret & ~br_taken & (cnt_q != '0);
    assign push    = call & jmp & ~br_taken;
    assign ras_hit = pop;
    assign ras_top = ras_q[top_q];
    // Pop-then-push rewrites the top slot in place; a push when full lands on the oldest slot.
    always_comb begin
        top_d  = (pop == push) ? top_q : pop ? ptr_dec(top_q) : ptr_inc(top_q);
        cnt_d  = (pop == push) ? cnt_q : pop ? cnt_q - 1'b1 :
                 (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1;
        wr_ptr = pop ? top_q : ptr_inc(top_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && push) ras_q[wr_ptr] <= pc_plus;
    end
`else
    logic unused_ras;
    assign unused_ras = call | (RAS_DEPTH < 2);
    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
`endif
    assign fire     = fv_q & fetch_ready;
    assign br_tgt   = br_base + (br_offset << SHIFT);
    assign redirect = br_taken | ret | jmp;
    assign rdr_tgt  = br_taken ? br_tgt : ras_hit ? ras_top : jmp_target;
    assign pc_plus  = pc_q + STEP;
    // Any redirect costs exactly one fetch bubble while the new target settles into pc.
    always_comb begin
        pc_d  = redirect ? (rdr_tgt & ~LOW) : (fire & ~stall) ? pc_plus : pc_q;
        fv_d  = ~redirect;
        mis_d = redirect & |(rdr_tgt & LOW);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            fv_q  <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            fv_q  <= fv_d;
            mis_q <= mis_d;
        end
    end
    assign pc          = pc_q;
    assign fetch_valid = fv_q;
    assign misalign    = mis_q;
endmodule
